// File: rtl/snapshot_pkg.sv
// rtl/snapshot_pkg.sv - shared types and constants for the frame snapshot DMA
// Contents: capture FSM state encoding, region tag width, header word encoding.
package snapshot_pkg;

    localparam int TAG_W       = 2;
    localparam int MAX_REGIONS = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_READ,
        ST_WAIT,
        ST_EMIT,
        ST_FINISH
    } state_t;

    // The region header carries the running capture count; the caller
    // truncates it to the stream word width.
    function automatic logic [31:0] hdr_word(input logic [31:0] frame);
        return frame;
    endfunction

endpackage

// File: rtl/snapshot_trig_sync.sv
// rtl/snapshot_trig_sync.sv - trigger synchronizer, edge detect and decimation
// Ports: clk, reset_n (async, active-low); trigger (async level);
//        enable (edge may count toward decimation); trig_edge (any rising
//        edge); trig_start (edge that begins a capture).
module snapshot_trig_sync #(
    parameter int DECIMATE = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic trigger,
    input  logic enable,
    output logic trig_edge,
    output logic trig_start
);

    localparam int DW = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;

    logic          sync1, sync2, sync_prev;
    logic [DW-1:0] dec_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
            dec_q     <= '0;
        end else begin
            sync1     <= trigger;
            sync2     <= sync1;
            sync_prev <= sync2;
            // Counter sits at 0 before a capturing edge, so the very first
            // accepted edge captures and then every DECIMATE-th after it.
            if (trig_edge && enable)
                dec_q <= (dec_q == DW'(DECIMATE - 1)) ? '0 : dec_q + 1'b1;
        end
    end

    assign trig_edge  = sync2 & ~sync_prev;
    assign trig_start = trig_edge & enable & (dec_q == '0);

endmodule

// File: rtl/frame_snapshot_dma.sv
// rtl/frame_snapshot_dma.sv - per-frame multi-window memory capture to a byte stream
// Ports: clk, reset_n (async, active-low); trigger (frame trigger level);
//        region_base/region_len (packed windows, region 0 in LSBs);
//        pulse_first/pulse_last (stimulus window); mem_addr/mem_rd/mem_rdata
//        (shared read port); out_data/out_tag/out_sof/out_eof/out_valid/
//        out_ready (stream); frame_cnt, busy, done, overrun, sw_pulse (status).
module frame_snapshot_dma
    import snapshot_pkg::*;
#(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 8,
    parameter int NREGIONS   = 2,
    parameter int RD_LAT     = 1,
    parameter int FRAME_W    = 16,
    parameter int DECIMATE   = 1,
    parameter int MAX_FRAMES = 0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         trigger,
    input  logic [NREGIONS*ADDR_W-1:0]   region_base,
    input  logic [NREGIONS*(ADDR_W+1)-1:0] region_len,
    input  logic [FRAME_W-1:0]           pulse_first,
    input  logic [FRAME_W-1:0]           pulse_last,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic                         mem_rd,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic [DATA_W-1:0]            out_data,
    output logic [TAG_W-1:0]             out_tag,
    output logic                         out_sof,
    output logic                         out_eof,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [FRAME_W-1:0]           frame_cnt,
    output logic                         busy,
    output logic                         done,
    output logic                         overrun,
    output logic                         sw_pulse
);

    localparam int LW = ADDR_W + 1;

    logic trig_edge, trig_start, trig_enable;

    assign trig_enable = !busy && !done;

    snapshot_trig_sync #(.DECIMATE(DECIMATE)) u_trig (
        .clk        (clk),
        .reset_n    (reset_n),
        .trigger    (trigger),
        .enable     (trig_enable),
        .trig_edge  (trig_edge),
        .trig_start (trig_start)
    );

    // Window inputs widened to the maximum region count so every region
    // index is in range regardless of NREGIONS.
    logic [MAX_REGIONS*ADDR_W-1:0] base_pad;
    logic [MAX_REGIONS*LW-1:0]     len_pad;
    assign base_pad = (MAX_REGIONS*ADDR_W)'(region_base);
    assign len_pad  = (MAX_REGIONS*LW)'(region_len);

    state_t            state;
    logic [TAG_W-1:0]  region_q, last_q;
    logic [LW-1:0]     offset_q;
    logic [1:0]        wait_q;
    logic [ADDR_W-1:0] base_q [MAX_REGIONS];
    logic [LW-1:0]     len_q  [MAX_REGIONS];

    logic [MAX_REGIONS-1:0] ne_in, ne_q;
    logic [TAG_W-1:0]       first_in, last_in, next_q;
    logic [LW-1:0]          off_nxt;
    logic [ADDR_W-1:0]      addr_nxt;
    logic [DATA_W-1:0]      hdr_data;

    always_comb begin
        ne_in    = '0;
        ne_q     = '0;
        first_in = '0;
        last_in  = '0;
        next_q   = '0;
        // Descending scan: the last hit is the lowest matching index.
        for (int i = MAX_REGIONS - 1; i >= 0; i--) begin
            ne_in[i] = |len_pad[i*LW +: LW];
            ne_q[i]  = |len_q[i];
            if (ne_in[i])
                first_in = TAG_W'(i);
            if (ne_q[i] && (TAG_W'(i) > region_q))
                next_q = TAG_W'(i);
        end
        for (int i = 0; i < MAX_REGIONS; i++)
            if (ne_in[i])
                last_in = TAG_W'(i);
    end

    assign off_nxt  = offset_q + 1'b1;
    assign addr_nxt = base_q[region_q] + off_nxt[ADDR_W-1:0];
    assign hdr_data = DATA_W'(hdr_word(32'(frame_cnt)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            region_q  <= '0;
            last_q    <= '0;
            offset_q  <= '0;
            wait_q    <= '0;
            for (int i = 0; i < MAX_REGIONS; i++) begin
                base_q[i] <= '0;
                len_q[i]  <= '0;
            end
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_valid <= 1'b0;
            frame_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            sw_pulse  <= 1'b0;
        end else begin
            // An empty or inverted window can never satisfy both bounds.
            sw_pulse <= (frame_cnt >= pulse_first) && (frame_cnt < pulse_last);

            if (trig_edge && busy && !done)
                overrun <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (trig_start) begin
                        for (int i = 0; i < MAX_REGIONS; i++) begin
                            base_q[i] <= base_pad[i*ADDR_W +: ADDR_W];
                            len_q[i]  <= len_pad[i*LW +: LW];
                        end
                        busy <= 1'b1;
                        if (|ne_in) begin
                            region_q  <= first_in;
                            last_q    <= last_in;
                            out_valid <= 1'b1;
                            out_data  <= hdr_data;
                            out_tag   <= first_in;
                            out_sof   <= 1'b1;
                            out_eof   <= 1'b0;
                            state     <= ST_HDR;
                        end else begin
                            state <= ST_FINISH;
                        end
                    end
                end
                ST_HDR: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_sof   <= 1'b0;
                        offset_q  <= '0;
                        mem_addr  <= base_q[region_q];
                        mem_rd    <= 1'b1;
                        state     <= ST_READ;
                    end
                end
                ST_READ: begin
                    mem_rd <= 1'b0;
                    wait_q <= 2'(RD_LAT - 1);
                    state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_q == '0) begin
                        out_data  <= mem_rdata;
                        out_valid <= 1'b1;
                        out_eof   <= (region_q == last_q) && (off_nxt == len_q[region_q]);
                        state     <= ST_EMIT;
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_eof   <= 1'b0;
                        if (off_nxt != len_q[region_q]) begin
                            offset_q <= off_nxt;
                            mem_addr <= addr_nxt;
                            mem_rd   <= 1'b1;
                            state    <= ST_READ;
                        end else if (region_q == last_q) begin
                            state <= ST_FINISH;
                        end else begin
                            region_q  <= next_q;
                            out_valid <= 1'b1;
                            out_data  <= hdr_data;
                            out_tag   <= next_q;
                            out_sof   <= 1'b1;
                            state     <= ST_HDR;
                        end
                    end
                end
                ST_FINISH: begin
                    frame_cnt <= frame_cnt + 1'b1;
                    busy      <= 1'b0;
                    if ((MAX_FRAMES != 0) && (frame_cnt + 1'b1 == FRAME_W'(MAX_FRAMES)))
                        done <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_snapshot_dma.sv
// tb/tb_frame_snapshot_dma.sv - scoreboard bench for frame_snapshot_dma
module tb_frame_snapshot_dma;

    localparam int AW = 13;
    localparam int FW = 16;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] tag;
        logic       sof;
        logic       eof;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n, trigger, out_ready;
    logic [2*AW-1:0]   region_base;
    logic [2*AW+1:0]   region_len;
    logic [FW-1:0]     pulse_first, pulse_last;
    logic [7:0]        mem_rdata;
    logic [AW-1:0]     mem_addr;
    logic              mem_rd, out_sof, out_eof, out_valid, busy, done, overrun, sw_pulse;
    logic [7:0]        out_data;
    logic [1:0]        out_tag;
    logic [FW-1:0]     frame_cnt;

    logic              trig_b, trig_c, one, unused;
    logic [7:0]        zero8;
    logic [AW-1:0]     b_addr, c_addr;
    logic [7:0]        b_data, c_data;
    logic [1:0]        b_tag, c_tag;
    logic [FW-1:0]     b_cnt, c_cnt;
    logic              b_rd, b_sof, b_eof, b_valid, b_busy, b_done, b_ovr, b_sw;
    logic              c_rd, c_sof, c_eof, c_valid, c_busy, c_done, c_ovr, c_sw;
    int                b_words = 0, c_words = 0;

    frame_snapshot_dma dut (
        .clk(clk), .reset_n(reset_n), .trigger(trigger),
        .region_base(region_base), .region_len(region_len),
        .pulse_first(pulse_first), .pulse_last(pulse_last),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .out_data(out_data), .out_tag(out_tag), .out_sof(out_sof), .out_eof(out_eof),
        .out_valid(out_valid), .out_ready(out_ready), .frame_cnt(frame_cnt),
        .busy(busy), .done(done), .overrun(overrun), .sw_pulse(sw_pulse)
    );

    frame_snapshot_dma #(.DECIMATE(3)) dut_dec (
        .clk(clk), .reset_n(reset_n), .trigger(trig_b),
        .region_base({13'h800, 13'h000}), .region_len({14'd2, 14'd4}),
        .pulse_first(16'd0), .pulse_last(16'd0),
        .mem_addr(b_addr), .mem_rd(b_rd), .mem_rdata(zero8),
        .out_data(b_data), .out_tag(b_tag), .out_sof(b_sof), .out_eof(b_eof),
        .out_valid(b_valid), .out_ready(one), .frame_cnt(b_cnt),
        .busy(b_busy), .done(b_done), .overrun(b_ovr), .sw_pulse(b_sw)
    );

    frame_snapshot_dma #(.MAX_FRAMES(2)) dut_max (
        .clk(clk), .reset_n(reset_n), .trigger(trig_c),
        .region_base({13'h800, 13'h000}), .region_len({14'd2, 14'd4}),
        .pulse_first(16'd0), .pulse_last(16'd0),
        .mem_addr(c_addr), .mem_rd(c_rd), .mem_rdata(zero8),
        .out_data(c_data), .out_tag(c_tag), .out_sof(c_sof), .out_eof(c_eof),
        .out_valid(c_valid), .out_ready(one), .frame_cnt(c_cnt),
        .busy(c_busy), .done(c_done), .overrun(c_ovr), .sw_pulse(c_sw)
    );

    assign one   = 1'b1;
    assign zero8 = 8'h00;
    assign unused = ^{b_addr, b_data, b_tag, b_rd, b_sof, b_eof, b_busy, b_done, b_ovr, b_sw,
                      c_addr, c_data, c_tag, c_rd, c_sof, c_eof, c_busy, c_sw};

    always @(posedge clk) begin
        if (b_valid) b_words <= b_words + 1;
        if (c_valid) c_words <= c_words + 1;
    end

    // Memory model, read latency 1.
    logic [7:0] mem [8192];
    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

    int    n_cmp = 0, n_bad = 0;
    beat_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every transfer, checks stall stability.
    beat_t prev;
    beat_t exp_b;
    logic  stall_prev = 1'b0;
    always @(negedge clk) begin
        if (!reset_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                check("stall_stable", {out_valid, out_data, out_tag, out_sof, out_eof}, {1'b1, prev});
            if (out_valid && !out_ready)
                check("no_rd_while_stalled", mem_rd, 0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_word: got %0h expected none", out_data);
                end else begin
                    exp_b = sb.pop_front();
                    check("stream_word", {out_data, out_tag, out_sof, out_eof}, exp_b);
                end
            end
            stall_prev = out_valid && !out_ready;
            prev       = {out_data, out_tag, out_sof, out_eof};
        end
    end

    logic rdy_mode = 1'b0;
    int   cyc = 0;
    always @(posedge clk) begin
        #1;
        cyc++;
        if (rdy_mode) out_ready = (cyc % 3 == 0);
    end

    logic [12:0] cb0, cb1;
    int          cl0, cl1;

    task automatic set_cfg(input logic [12:0] b0, input int l0, input logic [12:0] b1, input int l1);
        cb0 = b0; cl0 = l0; cb1 = b1; cl1 = l1;
        region_base = {b1, b0};
        region_len  = {14'(l1), 14'(l0)};
    endtask

    task automatic push_frame(input logic [7:0] hdr);
        int          lens[2];
        logic [12:0] bases[2];
        logic [12:0] a;
        int          last;
        lens  = '{cl0, cl1};
        bases = '{cb0, cb1};
        last  = -1;
        if (cl0 != 0) last = 0;
        if (cl1 != 0) last = 1;
        for (int r = 0; r < 2; r++) begin
            if (lens[r] != 0) begin
                sb.push_back(beat_t'{hdr, 2'(r), 1'b1, 1'b0});
                for (int k = 0; k < lens[r]; k++) begin
                    a = bases[r] + 13'(k);
                    sb.push_back(beat_t'{mem[a], 2'(r), 1'b0, (r == last) && (k == lens[r] - 1)});
                end
            end
        end
    endtask

    task automatic run_frame();
        int t;
        @(posedge clk); #1 trigger = 1'b1;
        t = 0;
        while (busy !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
        check("busy_rise", busy, 1);
        trigger = 1'b0;
        t = 0;
        while (busy !== 1'b0 && t < 400) begin @(posedge clk); #1; t++; end
        check("busy_fall", busy, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        for (int i = 0; i < 8192; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[13'h000] = 8'h11; mem[13'h001] = 8'h22; mem[13'h002] = 8'h33; mem[13'h003] = 8'h44;
        mem[13'h800] = 8'hA0; mem[13'h801] = 8'hA1; mem[13'h1FFF] = 8'h5F;
        reset_n = 1'b0; trigger = 1'b0; out_ready = 1'b1; trig_b = 1'b0; trig_c = 1'b0;
        pulse_first = '0; pulse_last = '0;
        set_cfg(13'h000, 4, 13'h800, 2);
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {out_valid, out_sof, out_eof, mem_rd, busy, done, overrun, sw_pulse,
                                frame_cnt, out_data, out_tag, mem_addr}, 0);
        @(negedge clk) reset_n = 1'b1;

        // Basic frame: hdr 00 / 11 22 33 44 / hdr 00 / A0 A1(eof).
        push_frame(8'h00);
        run_frame();
        check("frame_cnt_after_1", frame_cnt, 1);
        check("sb_empty_1", sb.size(), 0);
        check("no_overrun_1", overrun, 0);

        // Same window with back-pressure.
        rdy_mode = 1'b1;
        push_frame(8'h01);
        run_frame();
        rdy_mode = 1'b0;
        out_ready = 1'b1;
        check("frame_cnt_after_stall", frame_cnt, 2);
        check("sb_empty_stall", sb.size(), 0);

        // Region 0 empty, region 1 wraps past the top of the address space.
        set_cfg(13'h000, 0, 13'h1FFF, 2);
        push_frame(8'h02);
        run_frame();
        check("sb_empty_wrap", sb.size(), 0);
        // Region 1 empty: eof on the last word of region 0.
        set_cfg(13'h010, 3, 13'h800, 0);
        push_frame(8'h03);
        run_frame();
        check("sb_empty_r0only", sb.size(), 0);
        // Both empty: nothing streamed, frame still counted.
        set_cfg(13'h000, 0, 13'h000, 0);
        run_frame();
        check("frame_cnt_all_empty", frame_cnt, 5);

        // Overrun: second edge while busy.
        do_reset();
        set_cfg(13'h000, 4, 13'h800, 2);
        check("overrun_after_reset", overrun, 0);
        push_frame(8'h00);
        @(posedge clk); #1 trigger = 1'b1;
        t = 0;
        while (busy !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
        check("ovr_busy_rise", busy, 1);
        trigger = 1'b0;
        repeat (3) @(posedge clk);
        #1 trigger = 1'b1;
        repeat (3) @(posedge clk);
        #1 trigger = 1'b0;
        t = 0;
        while (busy !== 1'b0 && t < 400) begin @(posedge clk); #1; t++; end
        repeat (10) @(posedge clk);
        #1;
        check("overrun_set", overrun, 1);
        check("ovr_frame_cnt", frame_cnt, 1);
        check("ovr_busy_idle", busy, 0);
        check("ovr_sb_empty", sb.size(), 0);

        // Stimulus window [3,5).
        do_reset();
        pulse_first = 16'd3;
        pulse_last  = 16'd5;
        repeat (2) @(posedge clk);
        #1;
        check("sw_pulse_at_0", sw_pulse, 0);
        for (int k = 1; k <= 6; k++) begin
            push_frame(8'(k - 1));
            run_frame();
            check("sw_frame_cnt", frame_cnt, 64'(k));
            check("sw_pulse", sw_pulse, (k >= 3 && k < 5) ? 1 : 0);
        end
        check("sw_sb_empty", sb.size(), 0);

        // Reset asserted while a data word is stalled in EMIT.
        push_frame(8'h06);
        @(posedge clk); #1 trigger = 1'b1;
        t = 0;
        while (!(out_valid === 1'b1 && out_sof === 1'b0) && t < 100) begin @(posedge clk); #1; t++; end
        out_ready = 1'b0;
        trigger = 1'b0;
        check("reached_emit", {out_valid, out_sof}, 2'b10);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("async_reset_outputs", {out_valid, out_sof, out_eof, mem_rd, busy, done, overrun, sw_pulse,
                                      frame_cnt, out_data, out_tag, mem_addr}, 0);
        sb.delete();
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        repeat (20) @(posedge clk);

        // Decimation by 3: six edges capture on edges 1 and 4.
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1 trig_b = 1'b1;
            repeat (4) @(posedge clk);
            #1 trig_b = 1'b0;
            repeat (60) @(posedge clk);
        end
        #1;
        check("dec_frame_cnt", b_cnt, 2);
        check("dec_words", b_words, 16);

        // Frame limit of 2.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1 trig_c = 1'b1;
            repeat (4) @(posedge clk);
            #1 trig_c = 1'b0;
            repeat (60) @(posedge clk);
            #1;
            if (k == 0) check("max_done_after_1", c_done, 0);
            if (k == 1) check("max_done_after_2", c_done, 1);
        end
        check("max_words", c_words, 16);
        check("max_frame_cnt", c_cnt, 2);
        check("max_no_overrun", c_ovr, 0);
        check("max_done_sticky", c_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
